// File: rtl/sv32_ptw.sv
// sv32_ptw: two-level Sv32 page-table walker.
// It reads the level-1 PTE and, when that entry points to another table, the
// level-0 PTE. It returns the final PTE with superpage, page-fault and
// access-fault flags as a single-cycle response pulse.
module sv32_ptw #(
    parameter int unsigned PADDR_WIDTH        = 34,
    parameter int unsigned PTW_TIMEOUT_CYCLES = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_va_i,
    input  logic [31:0]            satp_i,
    output logic                   rsp_valid_o,
    output logic [63:0]            rsp_data_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [31:0]            mem_rsp_data_i,
    input  logic                   mem_rsp_err_i,
    output logic                   busy_o
);

    localparam int unsigned CNT_W = $clog2(PTW_TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP
    } state_e;

    state_e            state_q, state_d;
    logic [31:12]      va_q, va_d;
    logic [21:0]       ppn_q, ppn_d;
    logic [31:0]       pte_q, pte_d;
    logic              sp_q, sp_d, pf_q, pf_d, af_q, af_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout;
    logic              pte_invalid, pte_leaf, sp_misaligned;
    logic [33:0]       addr_full;
    logic              unused_bits;

    assign unused_bits = ^{satp_i[30:22], req_va_i[11:0]};

    // Classify the PTE on the response bus.
    always_comb begin
        pte_invalid   = !mem_rsp_data_i[0] || (!mem_rsp_data_i[1] && mem_rsp_data_i[2]);
        pte_leaf      = mem_rsp_data_i[1] || mem_rsp_data_i[3];
        sp_misaligned = (mem_rsp_data_i[19:10] != '0);
        timeout       = (cnt_q == CNT_W'(PTW_TIMEOUT_CYCLES - 1));
    end

    // Drive the handshake and status outputs, and form the PTE address for the current level.
    always_comb begin
        req_ready_o     = (state_q == IDLE);
        busy_o          = (state_q != IDLE);
        rsp_valid_o     = (state_q == RESP);
        mem_req_valid_o = (state_q == L1_REQ) || (state_q == L0_REQ);
        rsp_data_o      = {29'd0, af_q, pf_q, sp_q, pte_q};
        addr_full       = '0;
        if (state_q == L1_REQ) addr_full = {ppn_q, va_q[31:22], 2'b00};
        else if (state_q == L0_REQ) addr_full = {pte_q[31:10], va_q[21:12], 2'b00};
        mem_req_addr_o  = PADDR_WIDTH'(addr_full);
    end

    // Compute the next state and next register values of the walk.
    always_comb begin
        state_d = state_q;
        va_d    = va_q;
        ppn_d   = ppn_q;
        pte_d   = pte_q;
        sp_d    = sp_q;
        pf_d    = pf_q;
        af_d    = af_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    va_d  = req_va_i[31:12];
                    ppn_d = satp_i[21:0];
                    pte_d = '0;
                    sp_d  = 1'b0;
                    pf_d  = 1'b0;
                    af_d  = 1'b0;
                    cnt_d = '0;
                    if (satp_i[31]) begin
                        state_d = L1_REQ;
                    end else begin
                        af_d    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            L1_REQ, L0_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // No response can arrive here, so an expired budget ends the walk
                // even when the read is accepted in the same cycle.
                if (timeout) begin
                    af_d    = 1'b1;
                    state_d = RESP;
                end else if (mem_req_ready_i) begin
                    state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT, L0_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rsp_valid_i) begin
                    state_d = RESP;
                    if (mem_rsp_err_i) begin
                        af_d = 1'b1;
                    end else begin
                        pte_d = mem_rsp_data_i;
                        if (pte_invalid) begin
                            pf_d = 1'b1;
                        end else if (pte_leaf) begin
                            if (state_q == L1_WAIT) begin
                                if (sp_misaligned) pf_d = 1'b1;
                                else               sp_d = 1'b1;
                            end
                        end else if (state_q == L1_WAIT) begin
                            cnt_d   = '0;
                            state_d = L0_REQ;
                        end else begin
                            pf_d = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    af_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any walk in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Walk context, response registers and per-level timeout counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            va_q  <= '0;
            ppn_q <= '0;
            pte_q <= '0;
            sp_q  <= 1'b0;
            pf_q  <= 1'b0;
            af_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            va_q  <= va_d;
            ppn_q <= ppn_d;
            pte_q <= pte_d;
            sp_q  <= sp_d;
            pf_q  <= pf_d;
            af_q  <= af_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sv32_ptw.sv
// tb_sv32_ptw: directed walks with hand-computed PTE addresses, responses and latencies.
module tb_sv32_ptw;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_va_i;
    logic [31:0] satp_i;
    logic        rsp_valid_o;
    logic [63:0] rsp_data_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [33:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_err_i;
    logic        busy_o;

    int nvec = 0;
    int nmis = 0;

    sv32_ptw #(.PADDR_WIDTH(34), .PTW_TIMEOUT_CYCLES(256)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_va_i        (req_va_i),
        .satp_i          (satp_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and play memory. Reads are always accepted at once; each read
    // is answered dly cycles after its handshake (dly=0: never). lat counts cycles
    // from acceptance to the response pulse.
    task automatic run_walk(input logic [31:0] satp, input logic [31:0] va,
                            input logic [31:0] p1, input logic [31:0] p0,
                            input logic e1, input int dly,
                            output int lat, output int nreads, output logic [63:0] data,
                            output logic [33:0] a1, output logic [33:0] a0);
        int  cd;
        bit  got;
        @(negedge clk_i);
        check("ready_idle", {63'd0, req_ready_o}, 64'd1);
        req_valid_i     = 1'b1;
        req_va_i        = va;
        satp_i          = satp;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lat = 1; nreads = 0; cd = 0; got = 0; data = '0; a1 = '0; a0 = '0;
        while (!got && lat < 600) begin
            if (rsp_valid_o) begin
                got  = 1;
                data = rsp_data_o;
            end else begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_err_i   = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        mem_rsp_valid_i = 1'b1;
                        mem_rsp_data_i  = (nreads == 1) ? p1 : p0;
                        mem_rsp_err_i   = (nreads == 1) ? e1 : 1'b0;
                    end
                end
                if (mem_req_valid_o) begin
                    nreads++;
                    if (nreads == 1) a1 = mem_req_addr_o;
                    else             a0 = mem_req_addr_o;
                    cd = dly;
                end
                @(negedge clk_i);
                lat++;
            end
        end
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
        if (!got) check("rsp_timeout", 64'd0, 64'd1);
        @(negedge clk_i);
        check("pulse_one_cycle", {62'd0, rsp_valid_o, busy_o}, 64'd0);
    endtask

    int          lat, nr;
    logic [63:0] d;
    logic [33:0] a1, a0;

    initial begin
        rst_ni          = 1'b0;
        req_valid_i     = 1'b0;
        req_va_i        = '0;
        satp_i          = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_err_i   = 1'b0;
        #1;
        check("rst_outs", {60'd0, rsp_valid_o, mem_req_valid_o, busy_o, 1'b0}, 64'd0);
        check("rst_data", rsp_data_o, 64'd0);
        check("rst_addr", {30'd0, mem_req_addr_o}, 64'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", {63'd0, req_ready_o}, 64'd1);

        // Two-level walk
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0000_0401, 32'h2000_00CF, 1'b0, 1, lat, nr, d, a1, a0);
        check("walk2_data", d, 64'h0000_0000_2000_00CF);
        check("walk2_lat", 64'(lat), 64'd5);
        check("walk2_l1_addr", {30'd0, a1}, 64'h0010_0004);
        check("walk2_l0_addr", {30'd0, a0}, 64'h0000_100C);

        // Superpage
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0040_000F, 32'h0, 1'b0, 1, lat, nr, d, a1, a0);
        check("super_data", d, 64'h0000_0001_0040_000F);
        check("super_lat", 64'(lat), 64'd3);
        check("super_reads", 64'(nr), 64'd1);

        // Misaligned superpage
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0000_040F, 32'h0, 1'b0, 1, lat, nr, d, a1, a0);
        check("misal_flags", {62'd0, d[34:33]}, 64'd1);
        check("misal_reads", 64'(nr), 64'd1);

        // Invalid PTE
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0000_0000, 32'h0, 1'b0, 1, lat, nr, d, a1, a0);
        check("inval_data", d, 64'h0000_0002_0000_0000);

        // W without R is invalid
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0000_0005, 32'h0, 1'b0, 1, lat, nr, d, a1, a0);
        check("wnr_data", d, 64'h0000_0002_0000_0005);

        // Pointer at level 0
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0000_0401, 32'h0000_0401, 1'b0, 1, lat, nr, d, a1, a0);
        check("l0ptr_data", d, 64'h0000_0002_0000_0401);

        // Bus error at level 1
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0040_000F, 32'h0, 1'b1, 1, lat, nr, d, a1, a0);
        check("err_flags", {62'd0, d[34:33]}, 64'd2);

        // Bare mode
        run_walk(32'h0000_0100, 32'h0040_3000, 32'h0, 32'h0, 1'b0, 1, lat, nr, d, a1, a0);
        check("bare_data", d, 64'h0000_0004_0000_0000);
        check("bare_reads", 64'(nr), 64'd0);
        check("bare_lat", 64'(lat), 64'd1);

        // Timeout, no response
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0, 32'h0, 1'b0, 0, lat, nr, d, a1, a0);
        check("tmo_data", d, 64'h0000_0004_0000_0000);
        check("tmo_lat_from_l1req", 64'(lat - 1), 64'd256);

        // Response in the final budget cycle wins over the timeout
        run_walk(32'h8000_0100, 32'h0040_3000, 32'h0040_000F, 32'h0, 1'b0, 255, lat, nr, d, a1, a0);
        check("edge_data", d, 64'h0000_0001_0040_000F);
        check("edge_lat", 64'(lat), 64'd257);

        // Stray response while idle
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0040_000F;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
        check("stray_idle", {61'd0, rsp_valid_o, busy_o, req_ready_o}, 64'd1);

        // Reset in L0_WAIT
        @(negedge clk_i);
        req_valid_i     = 1'b1;
        satp_i          = 32'h8000_0100;
        req_va_i        = 32'h0040_3000;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);                 // L1_REQ
        req_valid_i = 1'b0;
        @(negedge clk_i);                 // L1_WAIT
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0000_0401;
        @(negedge clk_i);                 // L0_REQ
        mem_rsp_valid_i = 1'b0;
        check("l0req_addr", {30'd0, mem_req_addr_o}, 64'h0000_100C);
        @(negedge clk_i);                 // L0_WAIT
        check("l0wait_busy", {62'd0, busy_o, mem_req_valid_o}, 64'd2);
        rst_ni = 1'b0;
        #1;
        check("midrst_outs", {61'd0, rsp_valid_o, busy_o, mem_req_valid_o}, 64'd0);
        check("midrst_data", rsp_data_o, 64'd0);
        @(negedge clk_i);
        rst_ni          = 1'b1;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h2000_00CF;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (rsp_valid_o || busy_o) seen = 1'b1;
                @(negedge clk_i);
            end
            check("postrst_quiet", {63'd0, seen}, 64'd0);
        end
        check("postrst_ready", {63'd0, req_ready_o}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
